// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one memory read per PC-unit fetch request,
// latches the byte-swapped instruction word and exposes its decode fields.
module instruction_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        fetch_req,
    output logic [31:0] address,
    output logic        read,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        stall,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs_idx,
    output logic [4:0]  rt_idx,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] target26,
    output logic        active,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_DONE  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    // Memory returns little-endian lanes; the CPU expects big-endian words.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        active_q, active_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        stall_s;

    // Next-state, datapath updates and the combinational stall to the PC unit.
    always_comb begin
        state_d       = state_q;
        address_d     = address_q;
        read_d        = read_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        active_d      = active_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;
        stall_s       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (!fetch_req) begin
                    state_d = state_q;
                end else if (pc == 32'd0) begin
                    state_d  = S_HALT;
                    active_d = 1'b0;
                end else if (pc[1:0] != 2'b00) begin
                    state_d  = S_FAULT;
                    fault_d  = 1'b1;
                    active_d = 1'b0;
                end else begin
                    state_d       = S_REQ;
                    address_d     = pc;
                    read_d        = 1'b1;
                    instr_valid_d = 1'b0;
                    stall_s       = 1'b1;
                end
            end
            S_REQ: begin
                // Completion cycle releases stall so the PC advances exactly once.
                if (waitrequest) begin
                    stall_s = 1'b1;
                end else begin
                    instr_d       = byte_swap(readdata);
                    instr_valid_d = 1'b1;
                    read_d        = 1'b0;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = S_DONE;
                end
            end
            S_HALT: begin
                stall_s  = 1'b1;
                read_d   = 1'b0;
                active_d = 1'b0;
            end
            S_FAULT: begin
                stall_s  = 1'b1;
                read_d   = 1'b0;
                active_d = 1'b0;
                fault_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any in-flight transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            address_q     <= 32'd0;
            read_q        <= 1'b0;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            active_q      <= 1'b1;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            address_q     <= address_d;
            read_q        <= read_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            active_q      <= active_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign address     = address_q;
    assign read        = read_q;
    assign byteenable  = 4'b1111;
    assign stall       = stall_s;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign active      = active_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

    assign opcode   = instr_q[31:26];
    assign rs_idx   = instr_q[25:21];
    assign rt_idx   = instr_q[20:16];
    assign funct    = instr_q[5:0];
    assign imm16    = instr_q[15:0];
    assign target26 = instr_q[25:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stimulus pushes expected captures into
// a scoreboard queue; a monitor pops and compares on every instr_valid rise.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        fetch_req;
    logic [31:0] address;
    logic        read;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic        active;
    logic        fault;
    logic [31:0] fetch_count;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req),
        .address(address), .read(read), .byteenable(byteenable),
        .waitrequest(waitrequest), .readdata(readdata), .stall(stall),
        .instr(instr), .instr_valid(instr_valid), .opcode(opcode),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .funct(funct), .imm16(imm16),
        .target26(target26), .active(active), .fault(fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each new capture must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (instr_valid === 1'b1 && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_capture: got instr %h with no expected entry", instr);
            end else begin
                e = sb_q.pop_front();
                check("instr", instr, e.instr);
                check("fetch_count", fetch_count, e.cnt);
                check("opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
                check("rs_idx", {27'd0, rs_idx}, {27'd0, e.instr[25:21]});
                check("rt_idx", {27'd0, rt_idx}, {27'd0, e.instr[20:16]});
                check("funct", {26'd0, funct}, {26'd0, e.instr[5:0]});
                check("imm16", {16'd0, imm16}, {16'd0, e.instr[15:0]});
                check("target26", {6'd0, target26}, {6'd0, e.instr[25:0]});
            end
        end
        prev_valid <= (instr_valid === 1'b1);
    end

    // One fetch with nwait wait-state cycles; checks latency, stall and read shape.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] data,
                            input logic [31:0] exp_instr, input logic [31:0] exp_cnt,
                            input int nwait);
        int   cyc;
        int   stalls;
        int   reads;
        exp_t e;
        cyc = 0; stalls = 0; reads = 0;
        e.instr = exp_instr;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
        pc = a; fetch_req = 1'b1; readdata = data;
        while (!(reads > 0 && instr_valid === 1'b1) && cyc < 20) begin
            waitrequest = (read === 1'b1) && (reads < nwait);
            @(negedge clk);
            if (stall === 1'b1) stalls++;
            if (read === 1'b1) begin
                reads++;
                check("req_address", address, a);
                check("valid_low_in_req", {31'd0, instr_valid}, 32'd0);
            end
            tick();
            cyc++;
        end
        waitrequest = 1'b0;
        fetch_req = 1'b0;
        check("fetch_latency", cyc, nwait + 2);
        check("stall_cycles", stalls, nwait + 1);
        check("read_cycles", reads, nwait + 1);
    endtask

    // DONE with fetch_req low must hold the captured word with no read.
    task automatic hold_done(input logic [31:0] exp_instr);
        @(negedge clk);
        check("done_stall", {31'd0, stall}, 32'd0);
        tick();
        @(negedge clk);
        check("done_read", {31'd0, read}, 32'd0);
        check("done_instr", instr, exp_instr);
        check("done_valid", {31'd0, instr_valid}, 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = 32'd0; fetch_req = 1'b0; waitrequest = 1'b0; readdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_address", address, 32'd0);
        check("rst_read", {31'd0, read}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("byteenable", {28'd0, byteenable}, 32'h0000_000F);
        check("rst_stall", {31'd0, stall}, 32'd0);
        tick();

        // Reset mid-transfer, with address held while waitrequest is high.
        pc = 32'hBFC0_0010; fetch_req = 1'b1; waitrequest = 1'b1;
        @(negedge clk);
        check("req_launch_stall", {31'd0, stall}, 32'd1);
        tick();
        pc = 32'h1234_5678; fetch_req = 1'b0;
        @(negedge clk);
        check("wait_read", {31'd0, read}, 32'd1);
        check("wait_addr", address, 32'hBFC0_0010);
        check("wait_stall", {31'd0, stall}, 32'd1);
        tick();
        @(negedge clk);
        check("wait_addr_hold", address, 32'hBFC0_0010);
        rst = 1'b1;
        tick();
        rst = 1'b0; waitrequest = 1'b0;
        @(negedge clk);
        check("abort_read", {31'd0, read}, 32'd0);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        check("abort_count", fetch_count, 32'd0);
        check("abort_instr", instr, 32'd0);
        tick();

        // Zero-wait, wait-state and back-to-back fetches.
        do_fetch(32'hBFC0_0000, 32'h0C00_0024, 32'h2400_000C, 32'd1, 0);
        hold_done(32'h2400_000C);
        do_fetch(32'hBFC0_0100, 32'h1234_5678, 32'h7856_3412, 32'd2, 3);
        do_fetch(32'hBFC0_0004, 32'hAABB_CCDD, 32'hDDCC_BBAA, 32'd3, 0);
        hold_done(32'hDDCC_BBAA);

        // Halt on pc==0: no reads afterwards even with a legal pc.
        pc = 32'd0; fetch_req = 1'b1;
        tick();
        @(negedge clk);
        check("halt_active", {31'd0, active}, 32'd0);
        tick();
        pc = 32'hBFC0_0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("halt_read", {31'd0, read}, 32'd0);
            check("halt_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        check("halt_count", fetch_count, 32'd3);
        fetch_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("halt_rst_active", {31'd0, active}, 32'd1);
        check("halt_rst_count", fetch_count, 32'd0);
        tick();

        // Unaligned pc faults without a read; reset clears it.
        pc = 32'hBFC0_0002; fetch_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fault_flag", {31'd0, fault}, 32'd1);
            check("fault_active", {31'd0, active}, 32'd0);
            check("fault_read", {31'd0, read}, 32'd0);
            check("fault_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        fetch_req = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("fault_rst_flag", {31'd0, fault}, 32'd0);
        check("fault_rst_active", {31'd0, active}, 32'd1);
        tick();

        check("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
